// File: rtl/way_replace_ctrl.sv
// Per-set tree-PLRU victim-way scheduler with a single outstanding miss.
// Latency: vict_ack one cycle after accept; PLRU updates visible next cycle (victim walk sees a same-cycle hit).
// Backpressure: vict_rdy low from the ack cycle until the cycle after fill/cancel; requests while not ready are dropped.
module way_replace_ctrl #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64,
  parameter int IDX_W   = $clog2(SET_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vict_req,
  input  logic [IDX_W-1:0]   vict_idx,
  input  logic [WAY_NUM-1:0] vict_way_vld,
  output logic               vict_rdy,
  output logic               vict_ack,
  output logic [WAY_NUM-1:0] vict_way,
  output logic               vict_inv,
  input  logic               hit_vld,
  input  logic [IDX_W-1:0]   hit_idx,
  input  logic [WAY_NUM-1:0] hit_way,
  input  logic               fill_vld,
  input  logic               fill_cancel,
  output logic               busy
);

  localparam int WAY_W  = $clog2(WAY_NUM);
  localparam int NODE_N = WAY_NUM - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_WAIT} state_t;

  // Node of level l on a way's path is (2^l - 1) + (way's top l bits); the
  // way bit just below that prefix says which child the way lives under.
  // Touching a way points every node on its path at the other child.
  function automatic logic [NODE_N-1:0] plru_touch(input logic [NODE_N-1:0] cur,
                                                   input logic [WAY_W-1:0]  way);
    logic [NODE_N-1:0] res;
    res = cur;
    for (int l = 0; l < WAY_W; l++) begin
      for (int j = 0; j < (1 << l); j++) begin
        if (int'(way >> (WAY_W - l)) == j) res[(1 << l) - 1 + j] = ~way[WAY_W - 1 - l];
      end
    end
    return res;
  endfunction

  // Root-to-leaf walk: each visited node bit becomes the next way bit (1 = right).
  function automatic logic [WAY_W-1:0] plru_walk(input logic [NODE_N-1:0] cur);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int j = 0; j < (1 << l); j++) begin
        if (int'(way >> (WAY_W - l)) == j) way[WAY_W - 1 - l] = cur[(1 << l) - 1 + j];
      end
    end
    return way;
  endfunction

  // Lowest-index invalid way (only meaningful when at least one bit is clear).
  function automatic logic [WAY_W-1:0] first_zero(input logic [WAY_NUM-1:0] vld);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!vld[i]) way = WAY_W'(i);
    end
    return way;
  endfunction

  function automatic logic [WAY_W-1:0] onehot_enc(input logic [WAY_NUM-1:0] oh);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (oh[i]) way = WAY_W'(i);
    end
    return way;
  endfunction

  logic [NODE_N-1:0]  plru_q [SET_NUM];
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lat_idx_q;
  logic [WAY_W-1:0]   lat_way_q;
  logic [WAY_NUM-1:0] vict_way_q;
  logic               vict_inv_q;

  logic               hit_ok;
  logic [WAY_W-1:0]   hit_enc;
  logic [NODE_N-1:0]  hit_plru;
  logic [NODE_N-1:0]  vict_cur;
  logic               all_vld;
  logic [WAY_W-1:0]   vict_sel;
  logic [NODE_N-1:0]  fill_base;
  logic [NODE_N-1:0]  fill_plru;
  logic               accept;
  logic               fill_ok;

  // Datapath: hit decode, forwarded victim walk, and hit-then-fill merge for the fill set.
  always_comb begin
    hit_ok    = hit_vld && ($countones(hit_way) == 1);
    hit_enc   = onehot_enc(hit_way);
    hit_plru  = plru_touch(plru_q[hit_idx], hit_enc);
    vict_cur  = (hit_ok && (hit_idx == vict_idx)) ? hit_plru : plru_q[vict_idx];
    all_vld   = &vict_way_vld;
    vict_sel  = all_vld ? plru_walk(vict_cur) : first_zero(vict_way_vld);
    fill_base = (hit_ok && (hit_idx == lat_idx_q)) ? hit_plru : plru_q[lat_idx_q];
    fill_plru = plru_touch(fill_base, lat_way_q);
    accept    = (state_q == ST_IDLE) && vict_req;
    fill_ok   = (state_q == ST_WAIT) && fill_vld;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    vict_rdy = 1'b0;
    vict_ack = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        vict_rdy = 1'b1;
        busy     = 1'b0;
        if (vict_req) state_d = ST_RESP;
      end
      ST_RESP: begin
        vict_ack = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (fill_vld || fill_cancel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the granted victim at accept; outputs hold until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx_q  <= '0;
      lat_way_q  <= '0;
      vict_way_q <= '0;
      vict_inv_q <= 1'b0;
    end else if (accept) begin
      lat_idx_q  <= vict_idx;
      lat_way_q  <= vict_sel;
      vict_way_q <= {{(WAY_NUM-1){1'b0}}, 1'b1} << vict_sel;
      vict_inv_q <= ~all_vld;
    end
  end

  // PLRU state: hit update first, fill write last so a same-set fill lands on top of the hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= '0;
    end else begin
      if (hit_ok)  plru_q[hit_idx]   <= hit_plru;
      if (fill_ok) plru_q[lat_idx_q] <= fill_plru;
    end
  end

  assign vict_way = vict_way_q;
  assign vict_inv = vict_inv_q;

endmodule

// File: tb/tb_way_replace_ctrl.sv
module tb_way_replace_ctrl;

  localparam int WAY_NUM = 4;
  localparam int SET_NUM = 64;
  localparam int IDX_W   = 6;
  localparam int NODE_N  = WAY_NUM - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vict_req;
  logic [IDX_W-1:0]   vict_idx;
  logic [WAY_NUM-1:0] vict_way_vld;
  logic               vict_rdy;
  logic               vict_ack;
  logic [WAY_NUM-1:0] vict_way;
  logic               vict_inv;
  logic               hit_vld;
  logic [IDX_W-1:0]   hit_idx;
  logic [WAY_NUM-1:0] hit_way;
  logic               fill_vld;
  logic               fill_cancel;
  logic               busy;

  way_replace_ctrl #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vict_req     (vict_req),
    .vict_idx     (vict_idx),
    .vict_way_vld (vict_way_vld),
    .vict_rdy     (vict_rdy),
    .vict_ack     (vict_ack),
    .vict_way     (vict_way),
    .vict_inv     (vict_inv),
    .hit_vld      (hit_vld),
    .hit_idx      (hit_idx),
    .hit_way      (hit_way),
    .fill_vld     (fill_vld),
    .fill_cancel  (fill_cancel),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: heap-ordered tree bits, node k has children 2k+1 / 2k+2.
  bit         m_plru [SET_NUM][NODE_N];
  bit         m_busy;
  bit         m_ack;
  int         m_idx;
  int         m_way;
  bit         m_inv;
  logic [3:0] m_way_oh;

  function automatic logic [3:0] b4(input logic x);
    return {3'b000, x};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SET_NUM; s++)
      for (int k = 0; k < NODE_N; k++) m_plru[s][k] = 1'b0;
    m_busy = 0; m_ack = 0; m_idx = 0; m_way = 0; m_inv = 0; m_way_oh = 4'b0000;
  endtask

  // Walk up from the leaf, pointing each ancestor at the sibling subtree.
  task automatic model_touch(input int s, input int w);
    int n;
    int p;
    n = NODE_N + w;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_plru[s][p] = (n == 2 * p + 1);
      n = p;
    end
  endtask

  function automatic int model_walk(input int s);
    int n;
    n = 0;
    while (n < NODE_N) n = m_plru[s][n] ? 2 * n + 2 : 2 * n + 1;
    return n - NODE_N;
  endfunction

  // Apply what the DUT samples on the coming edge.
  task automatic model_edge();
    int w;
    if (!rst_n) return;
    if (hit_vld && $countones(hit_way) == 1) begin
      w = 0;
      for (int i = 0; i < WAY_NUM; i++) if (hit_way[i]) w = i;
      model_touch(int'(hit_idx), w);
    end
    if (!m_busy) begin
      if (vict_req) begin
        if (vict_way_vld != 4'b1111) begin
          w = 0;
          for (int i = WAY_NUM - 1; i >= 0; i--) if (!vict_way_vld[i]) w = i;
          m_inv = 1;
        end else begin
          w = model_walk(int'(vict_idx));
          m_inv = 0;
        end
        m_way = w; m_way_oh = 4'(1 << w); m_idx = int'(vict_idx);
        m_busy = 1; m_ack = 1;
      end
    end else if (m_ack) begin
      m_ack = 0;
    end else if (fill_vld) begin
      model_touch(m_idx, m_way);
      m_busy = 0;
    end else if (fill_cancel) begin
      m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    chk("rdy",  b4(vict_rdy), b4(!m_busy));
    chk("busy", b4(busy),     b4(m_busy));
    chk("ack",  b4(vict_ack), b4(m_ack));
    chk("way",  vict_way,     m_way_oh);
    chk("inv",  b4(vict_inv), b4(m_inv));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    vict_req = 0; vict_idx = '0; vict_way_vld = '0;
    hit_vld = 0; hit_idx = '0; hit_way = '0;
    fill_vld = 0; fill_cancel = 0;
  endtask

  // One complete miss: accept, ack, then fill (end_cancel=0) or cancel in the first WAIT cycle.
  task automatic do_miss(input int idx, input logic [3:0] vld, input bit end_cancel,
                         output logic [3:0] way, output logic inv);
    vict_req = 1; vict_idx = 6'(idx); vict_way_vld = vld;
    cycle();
    vict_req = 0;
    way = vict_way;
    inv = vict_inv;
    cycle();
    if (end_cancel) fill_cancel = 1; else fill_vld = 1;
    cycle();
    fill_vld = 0; fill_cancel = 0;
  endtask

  initial begin
    logic [3:0] w;
    logic       inv;

    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  b4(vict_rdy), 4'b0001);
    chk("rst_ack",  b4(vict_ack), 4'b0000);
    chk("rst_way",  vict_way,     4'b0000);
    chk("rst_inv",  b4(vict_inv), 4'b0000);
    chk("rst_busy", b4(busy),     4'b0000);
    rst_n = 1;
    cycle();

    // Fresh set: PLRU all zero walks to way 0; fill way0 -> later walk goes right.
    do_miss(5, 4'b1111, 0, w, inv);
    chk("p1_way", w, 4'b0001);
    chk("p1_inv", b4(inv), 4'b0000);
    do_miss(5, 4'b1111, 0, w, inv);
    chk("p2_way", w, 4'b0100);
    do_miss(5, 4'b1111, 0, w, inv);
    chk("p3_way", w, 4'b0010);

    // Invalid ways take priority; cancel leaves PLRU as it was.
    do_miss(9, 4'b1011, 1, w, inv);
    chk("inv1_way", w, 4'b0100);
    chk("inv1_inv", b4(inv), 4'b0001);
    do_miss(9, 4'b0000, 1, w, inv);
    chk("inv2_way", w, 4'b0001);
    chk("inv2_inv", b4(inv), 4'b0001);
    do_miss(9, 4'b1111, 1, w, inv);
    chk("inv3_way", w, 4'b0001);
    chk("inv3_inv", b4(inv), 4'b0000);

    // Same-cycle hit on the miss set is forwarded into the walk.
    hit_vld = 1; hit_idx = 6'd7; hit_way = 4'b0001;
    vict_req = 1; vict_idx = 6'd7; vict_way_vld = 4'b1111;
    cycle();
    hit_vld = 0; vict_req = 0;
    chk("fwd_way", vict_way, 4'b0100);
    cycle();
    fill_cancel = 1;
    cycle();
    fill_cancel = 0;

    // Non-one-hot hit is ignored.
    hit_vld = 1; hit_idx = 6'd8; hit_way = 4'b0011;
    cycle();
    hit_vld = 0;
    do_miss(8, 4'b1111, 1, w, inv);
    chk("nohot_way", w, 4'b0001);

    // Request held high: second grant only after cancel, no extra ack while busy.
    vict_req = 1; vict_idx = 6'd10; vict_way_vld = 4'b1111;
    cycle();
    cycle();
    cycle();
    chk("b2b_noack", b4(vict_ack), 4'b0000);
    fill_cancel = 1;
    cycle();
    fill_cancel = 0;
    chk("b2b_rdy", b4(vict_rdy), 4'b0001);
    cycle();
    chk("b2b_ack2", b4(vict_ack), 4'b0001);
    vict_req = 0;
    cycle();
    fill_vld = 1;
    cycle();
    fill_vld = 0;

    // Cancel is bit-identical; stray fill in IDLE does nothing.
    do_miss(11, 4'b1111, 0, w, inv);
    do_miss(11, 4'b1111, 1, w, inv);
    chk("cx1_way", w, 4'b0100);
    fill_vld = 1;
    cycle();
    fill_vld = 0;
    do_miss(11, 4'b1111, 1, w, inv);
    chk("cx2_way", w, 4'b0100);

    // Reset in WAIT: immediate idle, no ack ever for the aborted request.
    do_miss(12, 4'b1111, 0, w, inv);
    vict_req = 1; vict_idx = 6'd12; vict_way_vld = 4'b1111;
    cycle();
    vict_req = 0;
    cycle();
    rst_n = 0;
    #1;
    chk("arst_busy", b4(busy),     4'b0000);
    chk("arst_rdy",  b4(vict_rdy), 4'b0001);
    chk("arst_ack",  b4(vict_ack), 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle();
    do_miss(12, 4'b1111, 0, w, inv);
    chk("arst_way0", w, 4'b0001);

    // Randomized traffic against the model, sets confined to force collisions.
    for (int c = 0; c < 3000; c++) begin
      hit_vld      = ($urandom_range(1, 0) == 1);
      hit_idx      = 6'($urandom_range(7, 0));
      hit_way      = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3, 0));
      vict_req     = ($urandom_range(9, 0) < 6);
      vict_idx     = 6'($urandom_range(7, 0));
      vict_way_vld = ($urandom_range(1, 0) == 1) ? 4'b1111 : 4'($urandom);
      fill_vld     = ($urandom_range(9, 0) < 4);
      fill_cancel  = ($urandom_range(9, 0) < 3);
      cycle();
    end
    clear_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
